gate_tt_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 21 ++
 rtl/gate_tt_checker_if.sv | 25 ++
 rtl/gate_tt_checker.sv | 92 +++++++++
 tb/tb_gate_tt_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
// Truth tables are indexed by {in1, in0}: bit i is the expected out for vector i.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_checker_if.sv
// Control, stimulus and result signals between the checker (master) and the
// environment that starts it and hosts the gate under test (slave).
interface gate_tt_checker_if;

    logic       start;
    logic       in0;
    logic       in1;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        input  start, dut_out,
        output in0, in1, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, dut_out,
        input  in0, in1, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/gate_tt_checker.sv
// Walks a two-input gate through all four input vectors, holds each for SETTLE
// cycles, samples the gate's out and compares it against TRUTH_TABLE.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE = TT_XOR,
    parameter int unsigned SETTLE      = 1
) (
    input  logic              clk,
    input  logic              rst,
    gate_tt_checker_if.master bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [1:0] idx_next;
    logic       mismatch;

    assign idx_next = idx + 2'd1;
    assign mismatch = bus.dut_out != TRUTH_TABLE[idx];

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 2'd0;
            cnt           <= 4'd0;
            bus.in0       <= 1'b0;
            bus.in1       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_vec  <= 4'd0;
        end else begin
            case (state)
                // A start in DONE discards the held results exactly like a fresh run.
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= DRIVE;
                        idx           <= 2'd0;
                        cnt           <= 4'd0;
                        bus.in0       <= 1'b0;
                        bus.in1       <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.err_count <= 3'd0;
                        bus.fail_vec  <= 4'd0;
                    end
                end

                DRIVE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    if (mismatch) begin
                        bus.err_count     <= bus.err_count + 3'd1;
                        bus.fail_vec[idx] <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        bus.in0  <= 1'b0;
                        bus.in1  <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        // The last comparison lands on this same edge, so fold it in.
                        bus.pass <= (bus.err_count == 3'd0) && !mismatch;
                    end else begin
                        state   <= DRIVE;
                        idx     <= idx_next;
                        cnt     <= 4'd0;
                        bus.in0 <= idx_next[0];
                        bus.in1 <= idx_next[1];
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Randomised scoreboard bench: two checker instances (XOR/SETTLE=1, XNOR/SETTLE=3)
// driving behavioural gates; a monitor compares each completed run with the model.
module tb_gate_tt_checker;
    import gate_chk_pkg::*;

    localparam int G_ZERO = 0, G_AND = 1, G_OR = 2, G_XOR = 3,
                   G_NAND = 4, G_NOR = 5, G_XNOR = 6, G_ONE = 7;
    localparam int N_INST = 2;

    localparam logic [3:0] TT_K      [N_INST] = '{TT_XOR, TT_XNOR};
    localparam int         SETTLE_K  [N_INST] = '{1, 3};
    localparam int         REF_GATE  [N_INST] = '{G_XOR, G_XNOR};
    localparam logic [1:0] EXP_ORDER [4]      = '{2'b00, 2'b10, 2'b01, 2'b11};

    typedef struct {
        int         k;
        int         err;
        logic [3:0] fv;
        logic       pass;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             rst_r     [N_INST];
    logic             start_r   [N_INST];
    int               gsel      [N_INST];
    logic             glitch    [N_INST];
    logic [N_INST-1:0] in0_w, in1_w, busy_w, done_w, pass_w, dut_out_w;
    logic [2:0]       err_w     [N_INST];
    logic [3:0]       fail_w    [N_INST];

    exp_t sb[$];

    function automatic logic gate_fn(int g, logic a, logic b);
        case (g)
            G_ZERO:  return 1'b0;
            G_AND:   return a & b;
            G_OR:    return a | b;
            G_XOR:   return a ^ b;
            G_NAND:  return ~(a & b);
            G_NOR:   return ~(a | b);
            G_XNOR:  return ~(a ^ b);
            default: return 1'b1;
        endcase
    endfunction

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        gate_tt_checker_if ifc ();

        assign ifc.start    = start_r[g];
        assign ifc.dut_out  = dut_out_w[g];
        assign dut_out_w[g] = gate_fn(gsel[g], in0_w[g], in1_w[g]) ^ glitch[g];
        assign in0_w[g]     = ifc.in0;
        assign in1_w[g]     = ifc.in1;
        assign busy_w[g]    = ifc.busy;
        assign done_w[g]    = ifc.done;
        assign pass_w[g]    = ifc.pass;
        assign err_w[g]     = ifc.err_count;
        assign fail_w[g]    = ifc.fail_vec;

        gate_tt_checker #(
            .TRUTH_TABLE (TT_K[g]),
            .SETTLE      (SETTLE_K[g])
        ) u_dut (
            .clk (clk),
            .rst (rst_r[g]),
            .bus (ifc.master)
        );
    end

    task automatic check(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Corrupt the gate output during the first cycle after each stimulus change.
    logic [1:0] gprev_pair [N_INST];
    logic       gprev_busy [N_INST];
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N_INST; k++) begin
            glitch[k]     = busy_w[k] && (!gprev_busy[k] || {in0_w[k], in1_w[k]} != gprev_pair[k]);
            gprev_pair[k] = {in0_w[k], in1_w[k]};
            gprev_busy[k] = busy_w[k];
        end
    end

    // Monitor: records the (in0,in1) sequence and hold lengths, scores each finished run.
    logic [1:0] obs_pair [N_INST][8];
    int         obs_len  [N_INST][8];
    int         obs_n    [N_INST];
    logic       mprev_busy [N_INST];
    logic       mprev_done [N_INST];
    logic [1:0] mon_pair;
    exp_t       mon_e;

    always @(negedge clk) begin
        for (int k = 0; k < N_INST; k++) begin
            if (rst_r[k]) begin
                obs_n[k]      = 0;
                mprev_busy[k] = 1'b0;
                mprev_done[k] = 1'b0;
            end else begin
                if (busy_w[k]) begin
                    mon_pair = {in0_w[k], in1_w[k]};
                    if (!mprev_busy[k]) obs_n[k] = 0;
                    if (obs_n[k] > 0 && obs_pair[k][obs_n[k]-1] == mon_pair) begin
                        obs_len[k][obs_n[k]-1]++;
                    end else if (obs_n[k] < 8) begin
                        obs_pair[k][obs_n[k]] = mon_pair;
                        obs_len[k][obs_n[k]]  = 1;
                        obs_n[k]++;
                    end
                end
                if (done_w[k] && !mprev_done[k]) begin
                    if (sb.size() == 0 || sb[0].k != k) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL u%0d.unexpected_done: got done=1, expected no completion (cycle %0d)", k, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check($sformatf("u%0d.err_count", k), err_w[k], mon_e.err);
                        check($sformatf("u%0d.fail_vec", k), fail_w[k], mon_e.fv);
                        check($sformatf("u%0d.pass", k), pass_w[k], mon_e.pass);
                        check($sformatf("u%0d.busy_at_done", k), busy_w[k], 0);
                        check($sformatf("u%0d.done_cycle", k), cyc, mon_e.done_cyc);
                        check($sformatf("u%0d.vec_count", k), obs_n[k], 4);
                        for (int i = 0; i < 4 && i < obs_n[k]; i++) begin
                            check($sformatf("u%0d.vec%0d_order", k, i), obs_pair[k][i], EXP_ORDER[i]);
                            check($sformatf("u%0d.vec%0d_hold", k, i), obs_len[k][i], SETTLE_K[k] + 1);
                        end
                    end
                end
                mprev_busy[k] = busy_w[k];
                mprev_done[k] = done_w[k];
            end
        end
    end

    task automatic check_idle(int k, string tag);
        check($sformatf("u%0d.%s.in0", k, tag), in0_w[k], 0);
        check($sformatf("u%0d.%s.in1", k, tag), in1_w[k], 0);
        check($sformatf("u%0d.%s.busy", k, tag), busy_w[k], 0);
        check($sformatf("u%0d.%s.done", k, tag), done_w[k], 0);
        check($sformatf("u%0d.%s.pass", k, tag), pass_w[k], 0);
        check($sformatf("u%0d.%s.err_count", k, tag), err_w[k], 0);
        check($sformatf("u%0d.%s.fail_vec", k, tag), fail_w[k], 0);
    endtask

    // inj: 0 = clean run, 1 = extra start pulse mid-run, 2 = reset during vector 2.
    task automatic run(int k, int g, int inj);
        exp_t e;
        int   s;
        int   elapsed;
        int   r;
        int   n;
        logic a, b;
        s = SETTLE_K[k];
        e.k = k;
        e.err = 0;
        e.fv = 4'd0;
        for (int v = 0; v < 4; v++) begin
            a = 1'(v % 2);
            b = 1'(v / 2);
            if (gate_fn(g, a, b) != gate_fn(REF_GATE[k], a, b)) begin
                e.err++;
                e.fv[v] = 1'b1;
            end
        end
        e.pass = (e.err == 0);

        @(negedge clk);
        gsel[k]    = g;
        start_r[k] = 1'b1;
        e.done_cyc = cyc + 1 + 4 * (s + 1);
        if (inj != 2) sb.push_back(e);
        @(negedge clk);
        start_r[k] = 1'b0;
        elapsed    = 0;
        check($sformatf("u%0d.start.busy", k), busy_w[k], 1);
        check($sformatf("u%0d.start.done", k), done_w[k], 0);
        check($sformatf("u%0d.start.pass", k), pass_w[k], 0);
        check($sformatf("u%0d.start.fail_vec", k), fail_w[k], 0);

        if (inj == 1) begin
            r = $urandom_range(1, 4 * (s + 1) - 2);
            repeat (r) @(negedge clk);
            start_r[k] = 1'b1;
            @(negedge clk);
            start_r[k] = 1'b0;
        end else if (inj == 2) begin
            r = $urandom_range(2 * (s + 1), 3 * (s + 1) - 1);
            repeat (r) @(negedge clk);
            rst_r[k] = 1'b1;
            @(negedge clk);
            check_idle(k, "midrun_rst");
            rst_r[k] = 1'b0;
            return;
        end

        n = 0;
        while (!done_w[k] && n < 4 * (s + 1) + 8) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d.done_timeout", k), done_w[k], 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check($sformatf("u%0d.done_hold", k), done_w[k], 1);
        check($sformatf("u%0d.err_hold", k), err_w[k], e.err);
    endtask

    initial begin
        for (int k = 0; k < N_INST; k++) begin
            rst_r[k]      = 1'b1;
            start_r[k]    = 1'b0;
            gsel[k]       = G_ZERO;
            glitch[k]     = 1'b0;
            gprev_pair[k] = 2'b00;
            gprev_busy[k] = 1'b0;
            obs_n[k]      = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_INST; k++) check_idle(k, "reset");
        for (int k = 0; k < N_INST; k++) rst_r[k] = 1'b0;

        run(0, G_XOR,  0);
        run(0, G_ZERO, 0);
        run(0, G_XNOR, 0);
        run(1, G_XNOR, 0);
        run(1, G_XOR,  0);
        run(0, G_XOR,  1);
        run(0, G_XOR,  2);
        run(0, G_XOR,  0);
        run(0, G_XOR,  0);

        repeat (40) begin
            int r;
            int inj;
            r   = $urandom_range(0, 9);
            inj = (r == 0) ? 2 : (r <= 2) ? 1 : 0;
            run($urandom_range(0, N_INST - 1), $urandom_range(0, 7), inj);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
